// File: rtl/serial_slave_port.sv
// serial_slave_port: slave endpoint of the serial system bus.
// Receives address (and write data) LSB first, does one word access on a
// local synchronous memory and streams read data back LSB first. With
// SPLIT_EN set, reads are parked behind a SPLIT response and resumed on
// split_grant.
module serial_slave_port #(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 8,
   parameter bit SPLIT_EN      = 1'b0,
   parameter int SPLIT_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wdata,
   input  logic                  mode,
   input  logic                  mvalid,
   output logic                  rdata,
   output logic                  svalid,
   output logic                  ready,
   output logic                  split,
   input  logic                  split_grant,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam int SL_W  = $clog2(SPLIT_LATENCY + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [SL_W-1:0]  SL_LAST   = SL_W'(SPLIT_LATENCY - 1);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_ADDR       = 4'd1;
   localparam logic [3:0] S_WDATA      = 4'd2;
   localparam logic [3:0] S_MEM_WR     = 4'd3;
   localparam logic [3:0] S_MEM_RD     = 4'd4;
   localparam logic [3:0] S_RD_CAP     = 4'd5;
   localparam logic [3:0] S_RDATA      = 4'd6;
   localparam logic [3:0] S_SPLIT      = 4'd7;
   localparam logic [3:0] S_SPLIT_WAIT = 4'd8;
   localparam logic [3:0] S_SPLIT_RDY  = 4'd9;

   logic [3:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [SL_W-1:0]       sl_cnt;
   logic                  mode_q;
   logic [DATA_WIDTH-1:0] tx_sh;

   logic                  addr_done;
   logic                  is_write;
   logic [ADDR_WIDTH-1:0] addr_ins;
   logic [DATA_WIDTH-1:0] data_ins;

   // rdata comes straight off the TX shift register; it is zero outside a burst
   assign rdata    = tx_sh[0];
   assign addr_ins = mem_addr  | (ADDR_WIDTH'(wdata) << cnt);
   assign data_ins = mem_wdata | (DATA_WIDTH'(wdata) << cnt);
   // a one-bit address frame decides on the live mode bit, otherwise the latched one
   assign is_write = (state == S_IDLE) ? mode : mode_q;

   // flag the cycle in which the final address bit is accepted
   always_comb begin
      addr_done = 1'b0;
      if (mvalid) begin
         if (state == S_IDLE)
            addr_done = (ADDR_WIDTH == 1);
         else if (state == S_ADDR)
            addr_done = (cnt == ADDR_LAST);
      end
   end

   // transaction sequencer: deserialize, access memory, serialize, split handling
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sl_cnt    <= '0;
         mode_q    <= 1'b0;
         tx_sh     <= '0;
         svalid    <= 1'b0;
         ready     <= 1'b1;
         split     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         split  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mvalid) begin
                  mem_addr <= ADDR_WIDTH'(wdata);
                  mode_q   <= mode;
                  cnt      <= CNT_W'(1);
                  ready    <= 1'b0;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (mvalid) begin
                  mem_addr <= addr_ins;
                  cnt      <= cnt + 1'b1;
               end
            end
            S_WDATA: begin
               if (mvalid) begin
                  mem_wdata <= data_ins;
                  cnt       <= cnt + 1'b1;
                  if (cnt == DATA_LAST) begin
                     mem_we <= 1'b1;
                     state  <= S_MEM_WR;
                  end
               end
            end
            S_MEM_WR: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
            S_MEM_RD: begin
               state <= S_RD_CAP;
            end
            S_RD_CAP: begin
               tx_sh  <= mem_rdata;
               svalid <= 1'b1;
               cnt    <= '0;
               state  <= S_RDATA;
            end
            S_RDATA: begin
               if (cnt == DATA_LAST) begin
                  tx_sh  <= '0;
                  svalid <= 1'b0;
                  ready  <= 1'b1;
                  state  <= S_IDLE;
               end else begin
                  tx_sh <= tx_sh >> 1;
                  cnt   <= cnt + 1'b1;
               end
            end
            S_SPLIT: begin
               sl_cnt <= '0;
               state  <= S_SPLIT_WAIT;
            end
            S_SPLIT_WAIT: begin
               if (sl_cnt == SL_LAST) begin
                  ready <= 1'b1;
                  state <= S_SPLIT_RDY;
               end else begin
                  sl_cnt <= sl_cnt + 1'b1;
               end
            end
            S_SPLIT_RDY: begin
               if (split_grant) begin
                  ready  <= 1'b0;
                  mem_re <= 1'b1;
                  state  <= S_MEM_RD;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         // post-address decision overrides the per-state defaults above
         if (addr_done) begin
            cnt <= '0;
            if (is_write) begin
               mem_wdata <= '0;
               state     <= S_WDATA;
            end else if (SPLIT_EN) begin
               split <= 1'b1;
               state <= S_SPLIT;
            end else begin
               mem_re <= 1'b1;
               state  <= S_MEM_RD;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: one plain instance (a) and one
// split-enabled instance (b), each backed by a small synchronous memory model.
module tb_serial_slave_port;

   logic clk = 1'b0;
   logic rst, wdata, mode, mv_a, mv_b, grant_a, grant_b;
   logic rdata_a, svalid_a, ready_a, split_a, we_a, re_a;
   logic rdata_b, svalid_b, ready_b, split_b, we_b, re_b;
   logic [11:0] addr_a, addr_b;
   logic [7:0]  wd_a, wd_b, mrd_a, mrd_b;
   logic [7:0]  mem_a [0:4095];
   logic [7:0]  mem_b [0:4095];

   int n_checks = 0;
   int n_pass   = 0;
   int rdy_hi   = 0;
   int we_cnt_a = 0;
   int split_cnt_b = 0;

   always #5 clk = ~clk;

   serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_EN(1'b0), .SPLIT_LATENCY(4)) dut_a (
      .clk(clk), .rst(rst), .wdata(wdata), .mode(mode), .mvalid(mv_a),
      .rdata(rdata_a), .svalid(svalid_a), .ready(ready_a), .split(split_a),
      .split_grant(grant_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .mem_we(we_a), .mem_re(re_a), .mem_rdata(mrd_a));

   serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_EN(1'b1), .SPLIT_LATENCY(4)) dut_b (
      .clk(clk), .rst(rst), .wdata(wdata), .mode(mode), .mvalid(mv_b),
      .rdata(rdata_b), .svalid(svalid_b), .ready(ready_b), .split(split_b),
      .split_grant(grant_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .mem_we(we_b), .mem_re(re_b), .mem_rdata(mrd_b));

   // memory models: read data valid one cycle after mem_re
   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= wd_a;
      if (re_a) mrd_a <= mem_a[addr_a];
      if (we_b) mem_b[addr_b] <= wd_b;
      if (re_b) mrd_b <= mem_b[addr_b];
   end

   // pulse counters
   always @(posedge clk) begin
      if (we_a) we_cnt_a <= we_cnt_a + 1;
      if (split_b) split_cnt_b <= split_cnt_b + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // drive n bits LSB first; mode carries md only on the first bit
   task automatic drive_bits(input bit sel, input logic md, input logic [15:0] val,
                             input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         wdata = val[i];
         mode  = (i == 0) ? md : ~md;
         if (sel) mv_b = 1'b1; else mv_a = 1'b1;
         step(1);
         mv_a = 1'b0;
         mv_b = 1'b0;
         if (sel ? ready_b : ready_a) rdy_hi++;
         if (gap && i != n - 1) begin
            wdata = ~wdata;
            step(1);
            if (sel ? ready_b : ready_a) rdy_hi++;
         end
      end
   endtask

   // collect 8 beats starting at the first-beat cycle
   task automatic read_beats(input bit sel, output logic [7:0] val, output bit contig);
      val = '0;
      contig = 1'b1;
      for (int i = 0; i < 8; i++) begin
         val[i] = sel ? rdata_b : rdata_a;
         if ((sel ? svalid_b : svalid_a) !== 1'b1) contig = 1'b0;
         step(1);
      end
   endtask

   task automatic do_write(input bit sel, input logic [11:0] a, input logic [7:0] d);
      drive_bits(sel, 1'b1, {4'h0, a}, 12, 1'b0);
      drive_bits(sel, 1'b1, {8'h00, d}, 8, 1'b0);
      step(1);
   endtask

   task automatic do_read(input bit sel, input logic [11:0] a, output logic [7:0] val,
                          output bit contig);
      drive_bits(sel, 1'b0, {4'h0, a}, 12, 1'b0);
      step(2);
      read_beats(sel, val, contig);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(3);
      n_checks++; if (rdata_a !== 1'b0) $display("FAIL rst_rdata: got %b expected 0", rdata_a); else n_pass++;
      n_checks++; if (svalid_a !== 1'b0) $display("FAIL rst_svalid: got %b expected 0", svalid_a); else n_pass++;
      n_checks++; if (ready_a !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready_a); else n_pass++;
      n_checks++; if (split_a !== 1'b0) $display("FAIL rst_split_a: got %b expected 0", split_a); else n_pass++;
      n_checks++; if (we_a !== 1'b0) $display("FAIL rst_we: got %b expected 0", we_a); else n_pass++;
      n_checks++; if (re_a !== 1'b0) $display("FAIL rst_re: got %b expected 0", re_a); else n_pass++;
      n_checks++; if (addr_a !== 12'h000) $display("FAIL rst_addr: got %h expected 000", addr_a); else n_pass++;
      n_checks++; if (wd_a !== 8'h00) $display("FAIL rst_wdata: got %h expected 00", wd_a); else n_pass++;
      n_checks++; if (ready_b !== 1'b1) $display("FAIL rst_ready_b: got %b expected 1", ready_b); else n_pass++;
      n_checks++; if (split_b !== 1'b0) $display("FAIL rst_split_b: got %b expected 0", split_b); else n_pass++;
      rst = 1'b0;
      step(1);
      n_checks++; if (ready_a !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", ready_a); else n_pass++;
   endtask

   task automatic test_write_read;
      int w0;
      logic [7:0] v;
      bit c;
      w0 = we_cnt_a;
      rdy_hi = 0;
      drive_bits(1'b0, 1'b1, 16'h0123, 12, 1'b0);
      drive_bits(1'b0, 1'b1, 16'h005A, 8, 1'b0);
      n_checks++; if (we_a !== 1'b1) $display("FAIL wr_we: got %b expected 1", we_a); else n_pass++;
      n_checks++; if (addr_a !== 12'h123) $display("FAIL wr_addr: got %h expected 123", addr_a); else n_pass++;
      n_checks++; if (wd_a !== 8'h5A) $display("FAIL wr_data: got %h expected 5a", wd_a); else n_pass++;
      n_checks++; if (rdy_hi != 0) $display("FAIL wr_ready_low: got %0d high cycles expected 0", rdy_hi); else n_pass++;
      step(1);
      n_checks++; if (we_a !== 1'b0) $display("FAIL wr_we_pulse: got %b expected 0", we_a); else n_pass++;
      n_checks++; if (ready_a !== 1'b1) $display("FAIL wr_ready_back: got %b expected 1", ready_a); else n_pass++;
      n_checks++; if (we_cnt_a - w0 != 1) $display("FAIL wr_we_count: got %0d expected 1", we_cnt_a - w0); else n_pass++;
      drive_bits(1'b0, 1'b0, 16'h0123, 12, 1'b0);
      n_checks++; if (re_a !== 1'b1) $display("FAIL rd_re: got %b expected 1", re_a); else n_pass++;
      n_checks++; if (addr_a !== 12'h123) $display("FAIL rd_addr: got %h expected 123", addr_a); else n_pass++;
      step(1);
      n_checks++; if (svalid_a !== 1'b0) $display("FAIL rd_early_svalid: got %b expected 0", svalid_a); else n_pass++;
      step(1);
      read_beats(1'b0, v, c);
      n_checks++; if (v !== 8'h5A) $display("FAIL rd_data: got %h expected 5a", v); else n_pass++;
      n_checks++; if (c !== 1'b1) $display("FAIL rd_contig: got %b expected 1", c); else n_pass++;
      n_checks++; if (svalid_a !== 1'b0) $display("FAIL rd_svalid_end: got %b expected 0", svalid_a); else n_pass++;
      n_checks++; if (ready_a !== 1'b1) $display("FAIL rd_ready_end: got %b expected 1", ready_a); else n_pass++;
   endtask

   task automatic test_gapped;
      int w0;
      w0 = we_cnt_a;
      rdy_hi = 0;
      drive_bits(1'b0, 1'b1, 16'h07FF, 12, 1'b1);
      drive_bits(1'b0, 1'b1, 16'h00C3, 8, 1'b1);
      n_checks++; if (rdy_hi != 0) $display("FAIL gap_ready_low: got %0d high cycles expected 0", rdy_hi); else n_pass++;
      n_checks++; if (we_a !== 1'b1) $display("FAIL gap_we: got %b expected 1", we_a); else n_pass++;
      n_checks++; if (addr_a !== 12'h7FF) $display("FAIL gap_addr: got %h expected 7ff", addr_a); else n_pass++;
      n_checks++; if (wd_a !== 8'hC3) $display("FAIL gap_data: got %h expected c3", wd_a); else n_pass++;
      step(1);
      n_checks++; if (we_cnt_a - w0 != 1) $display("FAIL gap_we_count: got %0d expected 1", we_cnt_a - w0); else n_pass++;
   endtask

   task automatic test_extremes;
      logic [7:0] v;
      bit c;
      do_write(1'b0, 12'h000, 8'h01);
      do_write(1'b0, 12'hFFF, 8'h80);
      do_read(1'b0, 12'h000, v, c);
      n_checks++; if (v !== 8'h01) $display("FAIL ext_rd_000: got %h expected 01", v); else n_pass++;
      n_checks++; if (c !== 1'b1) $display("FAIL ext_contig_000: got %b expected 1", c); else n_pass++;
      drive_bits(1'b0, 1'b0, 16'h0FFF, 12, 1'b0);
      n_checks++; if (addr_a !== 12'hFFF) $display("FAIL ext_addr_fff: got %h expected fff", addr_a); else n_pass++;
      step(2);
      read_beats(1'b0, v, c);
      n_checks++; if (v !== 8'h80) $display("FAIL ext_rd_fff: got %h expected 80", v); else n_pass++;
   endtask

   task automatic test_split;
      logic [7:0] v;
      bit c;
      do_write(1'b1, 12'h456, 8'hA5);
      n_checks++; if (split_cnt_b != 0) $display("FAIL split_on_write: got %0d pulses expected 0", split_cnt_b); else n_pass++;
      drive_bits(1'b1, 1'b0, 16'h0456, 12, 1'b0);
      // k counts cycles after the one carrying the last address bit, minus one
      for (int k = 0; k < 12; k++) begin
         n_checks++; if (split_b !== (k == 0)) $display("FAIL split_pulse k=%0d: got %b expected %b", k, split_b, (k == 0)); else n_pass++;
         n_checks++; if (ready_b !== (k >= 5 && k <= 9)) $display("FAIL split_ready k=%0d: got %b expected %b", k, ready_b, (k >= 5 && k <= 9)); else n_pass++;
         n_checks++; if (re_b !== (k == 10)) $display("FAIL split_re k=%0d: got %b expected %b", k, re_b, (k == 10)); else n_pass++;
         grant_b = (k == 2 || k == 9);
         // stray bus traffic while parked in SPLIT_RDY must be ignored
         mv_b  = (k >= 6 && k <= 8);
         wdata = 1'b1;
         mode  = 1'b1;
         step(1);
      end
      grant_b = 1'b0;
      mv_b = 1'b0;
      n_checks++; if (svalid_b !== 1'b1) $display("FAIL split_first_beat: got %b expected 1", svalid_b); else n_pass++;
      read_beats(1'b1, v, c);
      n_checks++; if (v !== 8'hA5) $display("FAIL split_data: got %h expected a5", v); else n_pass++;
      n_checks++; if (c !== 1'b1) $display("FAIL split_contig: got %b expected 1", c); else n_pass++;
      n_checks++; if (ready_b !== 1'b1) $display("FAIL split_ready_end: got %b expected 1", ready_b); else n_pass++;
      n_checks++; if (split_cnt_b != 1) $display("FAIL split_count: got %0d expected 1", split_cnt_b); else n_pass++;
   endtask

   task automatic test_reset_mid_write;
      int w0;
      logic [7:0] v;
      bit c;
      w0 = we_cnt_a;
      drive_bits(1'b0, 1'b1, 16'h0010, 12, 1'b0);
      drive_bits(1'b0, 1'b1, 16'h00FF, 4, 1'b0);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      n_checks++; if (ready_a !== 1'b1) $display("FAIL rmw_ready: got %b expected 1", ready_a); else n_pass++;
      n_checks++; if (we_a !== 1'b0) $display("FAIL rmw_we: got %b expected 0", we_a); else n_pass++;
      step(3);
      n_checks++; if (we_cnt_a != w0) $display("FAIL rmw_no_write: got %0d writes expected 0", we_cnt_a - w0); else n_pass++;
      drive_bits(1'b0, 1'b1, 16'h0010, 12, 1'b0);
      drive_bits(1'b0, 1'b1, 16'h003C, 8, 1'b0);
      n_checks++; if (we_a !== 1'b1) $display("FAIL rmw_we2: got %b expected 1", we_a); else n_pass++;
      n_checks++; if (addr_a !== 12'h010) $display("FAIL rmw_addr: got %h expected 010", addr_a); else n_pass++;
      n_checks++; if (wd_a !== 8'h3C) $display("FAIL rmw_data: got %h expected 3c", wd_a); else n_pass++;
      step(1);
      do_read(1'b0, 12'h010, v, c);
      n_checks++; if (v !== 8'h3C) $display("FAIL rmw_readback: got %h expected 3c", v); else n_pass++;
   endtask

   task automatic test_reset_mid_read;
      logic [7:0] v;
      bit c;
      drive_bits(1'b0, 1'b0, 16'h0123, 12, 1'b0);
      step(2);
      n_checks++; if (svalid_a !== 1'b1) $display("FAIL rmr_beat1: got %b expected 1", svalid_a); else n_pass++;
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      n_checks++; if (svalid_a !== 1'b0) $display("FAIL rmr_svalid: got %b expected 0", svalid_a); else n_pass++;
      n_checks++; if (ready_a !== 1'b1) $display("FAIL rmr_ready: got %b expected 1", ready_a); else n_pass++;
      n_checks++; if (rdata_a !== 1'b0) $display("FAIL rmr_rdata: got %b expected 0", rdata_a); else n_pass++;
      do_read(1'b0, 12'h123, v, c);
      n_checks++; if (v !== 8'h5A) $display("FAIL rmr_next_read: got %h expected 5a", v); else n_pass++;
      n_checks++; if (c !== 1'b1) $display("FAIL rmr_contig: got %b expected 1", c); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; wdata = 1'b0; mode = 1'b0;
      mv_a = 1'b0; mv_b = 1'b0; grant_a = 1'b0; grant_b = 1'b0;
      test_reset();
      test_write_read();
      test_gapped();
      test_extremes();
      test_split();
      test_reset_mid_write();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Slave-side endpoint of the serial system bus. It deserializes the address and write-data bit stream driven through the interconnect, performs a single-word access on a local synchronous memory, and serializes read data back with `svalid`. It drives `ready` to the arbiter/decoder and, when configured, issues a SPLIT response for reads and resumes on `split_grant`. One instance sits behind each slave port (S1/S2 plain, S3 with split enabled).

## Interface

Parameters:
- `ADDR_WIDTH`, 12: local memory address bits received serially (11 for 2KB, 12 for 4KB).
- `DATA_WIDTH`, 8: data word width.
- `SPLIT_EN`, 0: 1 = reads answered with a SPLIT then resumed.
- `SPLIT_LATENCY`, 4: cycles held off (`ready`=0) after SPLIT before re-offering `ready`; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  bus clock, all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `wdata`  in  1  serial address/write-data bit, LSB first.
- `mode`  in  1  0 = read, 1 = write; sampled with the first address bit.
- `mvalid`  in  1  `wdata` bit valid this cycle.
- `rdata`  out  1  serial read-data bit, LSB first.
- `svalid`  out  1  `rdata` valid this cycle.
- `ready`  out  1  slave idle and able to accept a transaction.
- `split`  out  1  one-cycle SPLIT pulse (held 0 when `SPLIT_EN`=0).
- `split_grant`  in  1  arbiter grant to resume the split transaction.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid exactly 1 cycle after `mem_re`.

## Operation

- States: IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RD_CAP, RDATA, SPLIT, SPLIT_WAIT, SPLIT_RDY.
- IDLE: `ready`=1. On `mvalid`=1: addr[0]←`wdata`, latch `mode`, bit count←1; → ADDR (or, if ADDR_WIDTH=1, straight to the post-address decision).
- ADDR: each cycle with `mvalid`=1 shifts `wdata` into addr[count], count+1. After bit ADDR_WIDTH−1: write → WDATA (count←0); read → SPLIT if `SPLIT_EN`, else MEM_RD.
- WDATA: each `mvalid`=1 cycle captures data[count]; after bit DATA_WIDTH−1 → MEM_WR.
- MEM_WR: `mem_we`=1 for one cycle with `mem_addr`/`mem_wdata` stable → IDLE.
- MEM_RD: `mem_re`=1 for one cycle → RD_CAP; RD_CAP loads `mem_rdata` into the TX shift register → RDATA.
- RDATA: `svalid`=1, `rdata`=shift[0], shift right each cycle, DATA_WIDTH consecutive cycles, no gaps; then → IDLE.
- SPLIT: `split`=1 one cycle → SPLIT_WAIT; count SPLIT_LATENCY cycles with `ready`=0 → SPLIT_RDY: `ready`=1, wait for `split_grant`=1 → MEM_RD.
- `mvalid`=0 in ADDR/WDATA: hold state and count (gaps allowed, unbounded). `mvalid`, `wdata`, `mode` ignored in all other states, including SPLIT_RDY.
- Bit counter sized to cover max(ADDR_WIDTH, DATA_WIDTH); no wrap-around within a frame. Address is used as received; every value 0..2^ADDR_WIDTH−1 is legal, no range check.
- The slave never issues a SPLIT for writes.

## Timing

- Reset values: `rdata`=0, `svalid`=0, `ready`=1, `split`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0; state IDLE.
- `rst` mid-transaction: next cycle IDLE with reset outputs; a partially received write never reaches memory; an in-progress read burst is truncated.
- `ready` drops the cycle after the first accepted bit; it rises again the cycle after the final `svalid` beat or the `mem_we` cycle.
- Write latency: `mem_we` asserted 1 cycle after the last data bit is accepted.
- Read latency (no split): last address bit at cycle N → `mem_re` at N+1 → first `svalid` at N+3; last beat at N+2+DATA_WIDTH.
- Split read: `split` at N+1; `ready`=1 from N+2+SPLIT_LATENCY; `split_grant` seen at cycle G → `mem_re` at G+1, first `svalid` at G+3.
- `split_grant` asserted before SPLIT_RDY is ignored; it must be seen (high) in SPLIT_RDY.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Write then read (ADDR_WIDTH=12): write 0x5A to 0x123, back-to-back `mvalid` → one `mem_we` pulse, addr 0x123, data 0x5A; read 0x123 → `svalid` for 8 cycles, bits 0,1,0,1,1,0,1,0, first beat 3 cycles after the last address bit.
- Gapped stream: write 0xC3 to 0x7FF with `mvalid` low on every other cycle → identical `mem_we`, addr 0x7FF, data 0xC3; `ready` low throughout.
- Address extremes: read 0x000 and 0xFFF (memory preloaded 0x01/0x80) → rdata 0x01 and 0x80 serialized LSB first; no aliasing.
- Split read (SPLIT_EN=1, SPLIT_LATENCY=4): read 0x456 (mem 0xA5) → `split` one cycle at N+1, `ready`=0 N+1..N+5, `ready`=1 from N+6; early `split_grant` at N+3 ignored; grant at N+10 → `mem_re` at N+11, 0xA5 on `rdata` from N+13.
- Reset mid-write: assert `rst` after 4 data bits → no `mem_we`, `ready`=1 next cycle; subsequent full write of 0x3C to 0x010 succeeds.
- Reset mid-read: `rst` during third `svalid` beat → `svalid`=0 and `ready`=1 next cycle; next read returns correct data.
